dither_frame_ctrl: RTL and testbench

- Sequences the combinational `dithering` stage for the VGA output path.
- Generates 1024x768@60 pixel timing and splits 8-bit-per-channel source pixels into the 4-bit colour plus 2-bit remainder the stage consumes.
- Applies the dither switch only at frame boundaries and optionally alternates the dither phase every frame (temporal dithering).
- Registers the stage output into the VGA pins, with syncs delay-matched.

---
 rtl/dither_frame_ctrl_if.sv | 26 ++
 rtl/dither_frame_ctrl.sv | 157 +++++++++++++++
 tb/tb_dither_frame_ctrl.sv | 279 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/dither_frame_ctrl_if.sv
// Link between the frame controller and the combinational dithering stage:
// split colour/remainder and pixel parity out, dithered 4-bit colour back.
interface dither_frame_ctrl_if;
    logic       d_hc;
    logic       d_vc;
    logic       d_sw;
    logic [1:0] d_rms;
    logic [1:0] d_gms;
    logic [1:0] d_bms;
    logic [3:0] d_cer;
    logic [3:0] d_ceg;
    logic [3:0] d_ceb;
    logic [3:0] cr;
    logic [3:0] cg;
    logic [3:0] cb;

    modport master (
        output d_hc, d_vc, d_sw, d_rms, d_gms, d_bms, d_cer, d_ceg, d_ceb,
        input  cr, cg, cb
    );

    modport slave (
        input  d_hc, d_vc, d_sw, d_rms, d_gms, d_bms, d_cer, d_ceg, d_ceb,
        output cr, cg, cb
    );
endinterface

// File: rtl/dither_frame_ctrl.sv
// VGA timing, per-frame dither/phase latching and the two-stage pipeline that
// feeds the dithering stage and registers its result onto the VGA pins.
module dither_frame_ctrl #(
    parameter int H_VISIBLE = 1024,
    parameter int H_FP      = 24,
    parameter int H_SYNC    = 136,
    parameter int H_BP      = 160,
    parameter int V_VISIBLE = 768,
    parameter int V_FP      = 3,
    parameter int V_SYNC    = 6,
    parameter int V_BP      = 29,
    parameter bit SYNC_POL  = 1'b0
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                dither_sw,
    input  logic                temporal_en,
    input  logic [23:0]         rgb_in,
    output logic [10:0]         hc,
    output logic [9:0]          vc,
    dither_frame_ctrl_if.master dl,
    output logic [3:0]          vga_r,
    output logic [3:0]          vga_g,
    output logic [3:0]          vga_b,
    output logic                vga_hs,
    output logic                vga_vs,
    output logic                dither_active,
    output logic [7:0]          frame_cnt
);
    localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;

    localparam logic [10:0] H_LAST = 11'(H_TOTAL - 1);
    localparam logic [10:0] H_VIS  = 11'(H_VISIBLE);
    localparam logic [10:0] HS_BEG = 11'(H_VISIBLE + H_FP);
    localparam logic [10:0] HS_END = 11'(H_VISIBLE + H_FP + H_SYNC);
    localparam logic [9:0]  V_LAST = 10'(V_TOTAL - 1);
    localparam logic [9:0]  V_VIS  = 10'(V_VISIBLE);
    localparam logic [9:0]  VS_BEG = 10'(V_VISIBLE + V_FP);
    localparam logic [9:0]  VS_END = 10'(V_VISIBLE + V_FP + V_SYNC);

    logic       sw_meta, sw_sync, te_meta, te_sync;
    logic       temporal_lat, phase, frame_seen;
    logic       fs, active_now, phase_now;
    logic       vld_p0, hs_p0, vs_p0;
    logic       d_hc_p1, d_vc_p1, d_sw_p1, vld_p1, hs_p1, vs_p1;
    logic [1:0] d_rms_p1, d_gms_p1, d_bms_p1;
    logic [3:0] d_cer_p1, d_ceg_p1, d_ceb_p1;
    logic       unused_lsbs;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hc <= '0;
            vc <= '0;
        end else if (hc == H_LAST) begin
            hc <= '0;
            vc <= (vc == V_LAST) ? '0 : vc + 10'd1;
        end else begin
            hc <= hc + 11'd1;
        end
    end

    // Stage 0: current counter position and the frame-level settings that apply to it.
    // The frame-start pixel already uses the values being latched for its own frame.
    assign fs         = (hc == '0) && (vc == '0);
    assign active_now = fs ? sw_sync : dither_active;
    assign phase_now  = fs ? (temporal_lat & ~phase) : phase;
    assign vld_p0     = (hc < H_VIS) && (vc < V_VIS);
    assign hs_p0      = (hc >= HS_BEG) && (hc < HS_END);
    assign vs_p0      = (vc >= VS_BEG) && (vc < VS_END);
    assign unused_lsbs = ^{rgb_in[17:16], rgb_in[9:8], rgb_in[1:0]};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sw_meta       <= 1'b0;
            sw_sync       <= 1'b0;
            te_meta       <= 1'b0;
            te_sync       <= 1'b0;
            dither_active <= 1'b0;
            temporal_lat  <= 1'b0;
            phase         <= 1'b0;
            frame_seen    <= 1'b0;
            frame_cnt     <= '0;
        end else begin
            sw_meta <= dither_sw;
            sw_sync <= sw_meta;
            te_meta <= temporal_en;
            te_sync <= te_meta;
            if (fs) begin
                dither_active <= sw_sync;
                temporal_lat  <= te_sync;
                phase         <= phase_now;
                frame_seen    <= 1'b1;
                if (frame_seen)
                    frame_cnt <= frame_cnt + 8'd1;
            end
        end
    end

    // Stage 1: split source channels, parity/phase and delayed flags into the dithering stage.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            d_cer_p1 <= '0;
            d_ceg_p1 <= '0;
            d_ceb_p1 <= '0;
            d_rms_p1 <= '0;
            d_gms_p1 <= '0;
            d_bms_p1 <= '0;
            d_hc_p1  <= 1'b0;
            d_vc_p1  <= 1'b0;
            d_sw_p1  <= 1'b0;
            vld_p1   <= 1'b0;
            hs_p1    <= 1'b0;
            vs_p1    <= 1'b0;
        end else begin
            d_cer_p1 <= rgb_in[23:20];
            d_rms_p1 <= rgb_in[19:18];
            d_ceg_p1 <= rgb_in[15:12];
            d_gms_p1 <= rgb_in[11:10];
            d_ceb_p1 <= rgb_in[7:4];
            d_bms_p1 <= rgb_in[3:2];
            d_hc_p1  <= hc[0] ^ phase_now;
            d_vc_p1  <= vc[0] ^ phase_now;
            d_sw_p1  <= active_now;
            vld_p1   <= vld_p0;
            hs_p1    <= hs_p0;
            vs_p1    <= vs_p0;
        end
    end

    assign dl.d_cer = d_cer_p1;
    assign dl.d_ceg = d_ceg_p1;
    assign dl.d_ceb = d_ceb_p1;
    assign dl.d_rms = d_rms_p1;
    assign dl.d_gms = d_gms_p1;
    assign dl.d_bms = d_bms_p1;
    assign dl.d_hc  = d_hc_p1;
    assign dl.d_vc  = d_vc_p1;
    assign dl.d_sw  = d_sw_p1;

    // Stage 2: blank outside the visible area and map syncs to the pin polarity.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vga_r  <= '0;
            vga_g  <= '0;
            vga_b  <= '0;
            vga_hs <= ~SYNC_POL;
            vga_vs <= ~SYNC_POL;
        end else begin
            vga_r  <= vld_p1 ? dl.cr : 4'd0;
            vga_g  <= vld_p1 ? dl.cg : 4'd0;
            vga_b  <= vld_p1 ? dl.cb : 4'd0;
            vga_hs <= hs_p1 ? SYNC_POL : ~SYNC_POL;
            vga_vs <= vs_p1 ? SYNC_POL : ~SYNC_POL;
        end
    end
endmodule

// File: tb/tb_dither_frame_ctrl.sv
// Bench for dither_frame_ctrl on a reduced 16x10 raster: frame-level reference
// model checked every cycle, plus directed literal checks of key scenarios.
module tb_dither_frame_ctrl;
    localparam int HV = 8, HFP = 2, HSW = 3, HBP = 3;
    localparam int VV = 6, VFP = 1, VSW = 2, VBP = 1;
    localparam int HT = HV + HFP + HSW + HBP;
    localparam int VT = VV + VFP + VSW + VBP;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        dither_sw = 1'b0;
    logic        temporal_en = 1'b0;
    logic [23:0] rgb_in;
    logic [10:0] hc;
    logic [9:0]  vc;
    logic [3:0]  vga_r, vga_g, vga_b;
    logic        vga_hs, vga_vs, dither_active;
    logic [7:0]  frame_cnt;

    int vectors = 0;
    int miscompares = 0;
    int shown = 0;

    dither_frame_ctrl_if dl();

    dither_frame_ctrl #(
        .H_VISIBLE(HV), .H_FP(HFP), .H_SYNC(HSW), .H_BP(HBP),
        .V_VISIBLE(VV), .V_FP(VFP), .V_SYNC(VSW), .V_BP(VBP),
        .SYNC_POL(1'b0)
    ) dut (
        .clk(clk), .reset(reset), .dither_sw(dither_sw), .temporal_en(temporal_en),
        .rgb_in(rgb_in), .hc(hc), .vc(vc), .dl(dl),
        .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b),
        .vga_hs(vga_hs), .vga_vs(vga_vs),
        .dither_active(dither_active), .frame_cnt(frame_cnt)
    );

    always #5 clk = ~clk;

    // Stand-in dithering stage: 2x2 ordered threshold, +1 when remainder exceeds it.
    function automatic logic [3:0] dith(logic [3:0] ce, logic [1:0] ms, logic dh, logic dv, logic sw);
        logic [1:0] thr;
        case ({dh, dv})
            2'b00:   thr = 2'd0;
            2'b10:   thr = 2'd2;
            2'b01:   thr = 2'd3;
            default: thr = 2'd1;
        endcase
        return (sw && ms > thr && ce != 4'hF) ? ce + 4'd1 : ce;
    endfunction

    // Source image: white in blanking, a fixed test colour in column 1.
    function automatic logic [23:0] pattern(int h, int v);
        logic [7:0] r, g, b;
        if (h >= HV || v >= VV) return 24'hFFFFFF;
        if (h == 1) return 24'h8C4FFF;
        r = 8'(h * 37 + v * 11 + 64);
        g = 8'((h * 13) ^ (v * 29));
        b = 8'(h * 5 + v * 71 + 144);
        return {r, g, b};
    endfunction

    assign rgb_in = pattern(int'(hc), int'(vc));
    assign dl.cr = dith(dl.d_cer, dl.d_rms, dl.d_hc, dl.d_vc, dl.d_sw);
    assign dl.cg = dith(dl.d_ceg, dl.d_gms, dl.d_hc, dl.d_vc, dl.d_sw);
    assign dl.cb = dith(dl.d_ceb, dl.d_bms, dl.d_hc, dl.d_vc, dl.d_sw);

    typedef struct {
        int          frame;
        logic        act;
        logic        dh;
        logic        dv;
        logic [23:0] rgb;
        logic        vis;
        logic        hs;
        logic        vs;
    } rec_t;

    rec_t hist [4];
    int   t, frame;
    logic ph, act, tl;
    logic sw_prev, sw_cur, te_prev, te_cur;

    function automatic rec_t make_rec(int h, int v, int fr, logic p, logic a);
        rec_t r;
        r.frame = fr;
        r.act   = a;
        r.dh    = 1'(h % 2) ^ p;
        r.dv    = 1'(v % 2) ^ p;
        r.rgb   = pattern(h, v);
        r.vis   = (h < HV) && (v < VV);
        r.hs    = (h >= HV + HFP) && (h < HV + HFP + HSW);
        r.vs    = (v >= VV + VFP) && (v < VV + VFP + VSW);
        return r;
    endfunction

    function automatic rec_t blank_rec();
        rec_t r;
        r.frame = 0; r.act = 1'b0; r.dh = 1'b0; r.dv = 1'b0;
        r.rgb = '0; r.vis = 1'b0; r.hs = 1'b0; r.vs = 1'b0;
        return r;
    endfunction

    // Reference model: frame settings latched from switch values two edges old.
    initial begin
        rec_t p, q;
        int h, v;
        logic [64:0] got_v, exp_v;
        logic [3:0] er, eg, eb;
        forever begin
            @(posedge clk);
            if (reset) begin
                t = 0; frame = 0; ph = 1'b0; act = 1'b0; tl = 1'b0;
                sw_prev = 1'b0; sw_cur = 1'b0; te_prev = 1'b0; te_cur = 1'b0;
                hist[0] = make_rec(0, 0, 0, 1'b0, 1'b0);
                hist[3] = blank_rec();
            end else begin
                sw_prev = sw_cur; sw_cur = dither_sw;
                te_prev = te_cur; te_cur = temporal_en;
                t++;
                h = t % HT;
                v = (t / HT) % VT;
                if (h == 0 && v == 0) begin
                    frame++;
                    ph  = tl ? ~ph : 1'b0;
                    act = sw_prev;
                    tl  = te_prev;
                end
                hist[t & 3] = make_rec(h, v, frame, ph, act);
                p = hist[(t - 1) & 3];
                q = hist[(t - 2) & 3];
                #1;
                er = q.vis ? dith(q.rgb[23:20], q.rgb[19:18], q.dh, q.dv, q.act) : 4'd0;
                eg = q.vis ? dith(q.rgb[15:12], q.rgb[11:10], q.dh, q.dv, q.act) : 4'd0;
                eb = q.vis ? dith(q.rgb[7:4],   q.rgb[3:2],   q.dh, q.dv, q.act) : 4'd0;
                exp_v = {11'(h), 10'(v), p.dh, p.dv, p.act,
                         p.rgb[19:18], p.rgb[11:10], p.rgb[3:2],
                         p.rgb[23:20], p.rgb[15:12], p.rgb[7:4],
                         er, eg, eb, ~q.hs, ~q.vs, p.act, 8'(p.frame)};
                got_v = {hc, vc, dl.d_hc, dl.d_vc, dl.d_sw,
                         dl.d_rms, dl.d_gms, dl.d_bms,
                         dl.d_cer, dl.d_ceg, dl.d_ceb,
                         vga_r, vga_g, vga_b, vga_hs, vga_vs, dither_active, frame_cnt};
                vectors++;
                if (got_v !== exp_v) begin
                    miscompares++;
                    if (shown < 20) begin
                        shown++;
                        $display("FAIL cycle %0d (h=%0d v=%0d): got %h, expected %h", t, h, v, got_v, exp_v);
                    end
                end
            end
        end
    end

    task automatic chk(input string name, input int got, input int exp);
        vectors++;
        if (got != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d", name, got, exp);
        end
    endtask

    task automatic goto(input int h, input int v);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(int'(hc) == h && int'(vc) == v) && n < 400);
        if (!(int'(hc) == h && int'(vc) == v)) begin
            vectors++;
            miscompares++;
            $display("FAIL goto(%0d,%0d): timeout at hc=%0d vc=%0d", h, v, hc, vc);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        repeat (3) @(negedge clk);
        chk("rst_hc", int'(hc), 0);
        chk("rst_vc", int'(vc), 0);
        chk("rst_rgb", int'({vga_r, vga_g, vga_b}), 0);
        chk("rst_syncs", int'({vga_hs, vga_vs}), 3);
        chk("rst_d", int'({dl.d_cer, dl.d_ceg, dl.d_ceb, dl.d_rms, dl.d_gms, dl.d_bms, dl.d_hc, dl.d_vc, dl.d_sw}), 0);
        chk("rst_frame", int'({dither_active, frame_cnt}), 0);
        reset = 1'b0;

        // Frame 0: dither off; switch rises mid-frame and must not apply yet.
        goto(1, 1); repeat (2) @(negedge clk);
        chk("f0_r_nodither", int'(vga_r), 8);
        chk("f0_g_nodither", int'(vga_g), 4);
        goto(0, 3); dither_sw = 1'b1;
        goto(1, 5); repeat (2) @(negedge clk);
        chk("f0_r_after_rise", int'(vga_r), 8);
        chk("f0_active_held", int'(dither_active), 0);

        // Frame 1: dither applies from the frame start.
        goto(0, 0); @(negedge clk);
        chk("f1_active", int'(dither_active), 1);
        goto(1, 1); @(negedge clk);
        chk("f1_d_split", int'({dl.d_cer, dl.d_rms, dl.d_ceg, dl.d_gms, dl.d_ceb, dl.d_bms}),
            int'({4'd8, 2'd3, 4'd4, 2'd3, 4'd15, 2'd3}));
        chk("f1_d_parity", int'({dl.d_hc, dl.d_vc, dl.d_sw}), 7);
        @(negedge clk);
        chk("f1_vga_r", int'(vga_r), 9);
        chk("f1_vga_g", int'(vga_g), 5);
        chk("f1_vga_b", int'(vga_b), 15);

        // Temporal phase alternation and forced-zero phase.
        temporal_en = 1'b1;
        goto(0, 0); @(negedge clk);
        chk("f2_phase0", int'({dl.d_hc, dl.d_vc}), 0);
        goto(0, 0); @(negedge clk);
        chk("f3_phase1", int'({dl.d_hc, dl.d_vc}), 3);
        goto(0, 0); @(negedge clk);
        chk("f4_phase0", int'({dl.d_hc, dl.d_vc}), 0);
        temporal_en = 1'b0;
        goto(0, 0); @(negedge clk);
        chk("f5_phase1", int'({dl.d_hc, dl.d_vc}), 3);
        goto(0, 0); @(negedge clk);
        chk("f6_phase_forced0", int'({dl.d_hc, dl.d_vc}), 0);

        // Switch falls in the frame-start cycle itself: old value is latched.
        goto(0, 0); dither_sw = 1'b0;
        @(negedge clk);
        chk("f7_active_old", int'(dither_active), 1);
        goto(1, 1); repeat (2) @(negedge clk);
        chk("f7_vga_r", int'(vga_r), 9);
        goto(0, 0); @(negedge clk);
        chk("f8_active_new", int'(dither_active), 0);

        // Blanking and sync windows.
        goto(11, 2); repeat (2) @(negedge clk);
        chk("hsync_active", int'(vga_hs), 0);
        chk("blank_rgb", int'({vga_r, vga_g, vga_b}), 0);
        goto(13, 2); repeat (2) @(negedge clk);
        chk("hsync_end", int'(vga_hs), 1);
        goto(0, 7); repeat (2) @(negedge clk);
        chk("vsync_active", int'(vga_vs), 0);
        goto(0, 9); repeat (2) @(negedge clk);
        chk("vsync_end", int'(vga_vs), 1);

        // Frame counter wrap.
        n = 0;
        while (frame_cnt != 8'd255 && n < 50000) begin
            @(negedge clk);
            n++;
        end
        chk("frame_cnt_255", int'(frame_cnt), 255);
        goto(0, 0); @(negedge clk);
        chk("frame_cnt_wrap", int'(frame_cnt), 0);

        // Asynchronous mid-frame reset.
        goto(5, 4);
        #2 reset = 1'b1;
        #1;
        chk("async_rst_pos", int'({hc, vc}), 0);
        chk("async_rst_rgb", int'({vga_r, vga_g, vga_b}), 0);
        chk("async_rst_syncs", int'({vga_hs, vga_vs}), 3);
        chk("async_rst_d", int'({dl.d_cer, dl.d_ceg, dl.d_ceb, dl.d_sw}), 0);
        chk("async_rst_frame", int'({dither_active, frame_cnt}), 0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (5) @(negedge clk);
        chk("restart_hc", int'(hc), 5);
        chk("restart_vc", int'(vc), 0);
        repeat (400) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
